// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between fetch/LSU requesters, the port arbiter and the memory array.
// slave = arbiter view, master = requester/memory-side view.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port memory arbiter: LS priority with a streak limit so fetch cannot starve,
// one access per cycle, 1-cycle read response routed back to the issuing requester.
module imem_port_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 16,
  parameter int MAX_LS_STREAK = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  imem_port_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} owner_e;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  owner_e        own_q, own_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          if_req_eff, if_gnt, ls_gnt;
  mem_req_t      mreq;

  // Grants are gated by rst_n so nothing reaches the memory while reset is held.
  always_comb begin
    if_req_eff = bus.if_req & ~bus.if_flush;
    ls_gnt     = rst_n & bus.ls_req & (~if_req_eff | (streak_q < STREAK_MAX));
    if_gnt     = rst_n & if_req_eff & ~ls_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q    <= OWN_NONE;
      streak_q <= '0;
    end else begin
      own_q    <= own_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    own_d = OWN_NONE;
    if (if_gnt)                 own_d = OWN_IF;
    else if (ls_gnt & ~bus.ls_we) own_d = OWN_LS;

    // Only LS wins taken against a waiting fetch count toward the streak.
    streak_d = '0;
    if (ls_gnt & if_req_eff)
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
  end

  always_comb begin
    mreq = '0;
    if (ls_gnt) begin
      mreq.en    = 1'b1;
      mreq.we    = bus.ls_we;
      mreq.addr  = bus.ls_addr;
      mreq.wdata = bus.ls_wdata;
    end else if (if_gnt) begin
      mreq.en    = 1'b1;
      mreq.addr  = bus.if_addr;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_en    = mreq.en;
  assign bus.mem_we    = mreq.we;
  assign bus.mem_addr  = mreq.addr;
  assign bus.mem_wdata = mreq.wdata;

  // A flush in the response cycle kills the fetch data already on its way back.
  assign bus.if_rvalid = (own_q == OWN_IF) & ~bus.if_flush;
  assign bus.ls_rvalid = (own_q == OWN_LS);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;
endmodule
